// File: rtl/asynchronous_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// Occupancy is tracked by two ADDRESS_SIZE+1 bit pointers. The extra
// MSB is a wrap bit that tells "full" apart from "empty" when the
// address bits of the two pointers are equal.
module asynchronous_fifo #(
    parameter int DSIZE        = 8,
    parameter int ADDRESS_SIZE = 4
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty
);

    localparam int DEPTH = 1 << ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] PTR_ONE = 1;

    logic [DSIZE-1:0]      mem [DEPTH];
    logic [ADDRESS_SIZE:0] wptr;
    logic [ADDRESS_SIZE:0] rptr;
    logic                  write_en;
    logic                  read_en;

    // Requests are honoured only when the flags allow them. This is what
    // stops overflow while full and underflow while empty.
    assign write_en = winc & ~wfull;
    assign read_en  = rinc & ~rempty;

    // Store accepted write data at the write address.
    // NOTE: the storage array is deliberately left out of reset. Resetting
    // the pointers already empties the FIFO, and a reset on the array would
    // prevent it from mapping onto RAM.
    always_ff @(posedge wclk) begin
        if (wrst && write_en) begin
            mem[wptr[ADDRESS_SIZE-1:0]] <= wdata;
        end
    end

    // Write pointer. Reset takes priority over any write request.
    // NOTE: registers are updated with <= so that every always_ff block
    // samples the values that were present before the clock edge.
    always_ff @(posedge wclk) begin
        if (!wrst) begin
            wptr <= '0;
        end else if (write_en) begin
            wptr <= wptr + PTR_ONE;
        end
    end

    // Read pointer. Reset takes priority over any read request.
    always_ff @(posedge wclk) begin
        if (!wrst) begin
            rptr <= '0;
        end else if (read_en) begin
            rptr <= rptr + PTR_ONE;
        end
    end

    // Both flags are decoded from the registered pointers only, so they
    // change only after a clock edge. The FIFO is empty when all pointer
    // bits match. It is full when only the wrap bit differs.
    assign rempty = (wptr == rptr);
    assign wfull  = (wptr[ADDRESS_SIZE] != rptr[ADDRESS_SIZE]) &&
                    (wptr[ADDRESS_SIZE-1:0] == rptr[ADDRESS_SIZE-1:0]);

    // The head word is presented before the pop. Output is zero while empty.
    assign rdata = rempty ? '0 : mem[rptr[ADDRESS_SIZE-1:0]];

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Self-checking bench for asynchronous_fifo.
// A queue-based occupancy model is compared against the DUT on every
// falling edge. Directed scenarios add literal expectations that pin the
// model itself.
module tb_asynchronous_fifo;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 1 << ASIZE;

    logic             wclk = 1'b0;
    logic             wrst;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;

    int vectors    = 0;
    int miscompares = 0;
    bit check_en   = 1'b0;

    logic [DSIZE-1:0] model_q [$];

    asynchronous_fifo #(.DSIZE(DSIZE), .ADDRESS_SIZE(ASIZE)) dut (
        .wclk   (wclk),
        .wrst   (wrst),
        .winc   (winc),
        .wdata  (wdata),
        .rinc   (rinc),
        .rdata  (rdata),
        .wfull  (wfull),
        .rempty (rempty)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a reset clears the queue. Otherwise a read pops
    // when the queue holds data, and a write pushes when the queue has room.
    // Both decisions use the occupancy from before the edge.
    always @(posedge wclk) begin
        if (!wrst) begin
            model_q.delete();
        end else begin
            automatic bit do_rd = rinc && (model_q.size() > 0);
            automatic bit do_wr = winc && (model_q.size() < DEPTH);
            if (do_rd) void'(model_q.pop_front());
            if (do_wr) model_q.push_back(wdata);
        end
    end

    // Compare the DUT against the model every cycle, away from the active edge.
    always @(negedge wclk) begin
        if (check_en) begin
            check("rempty", 32'(rempty), 32'(model_q.size() == 0));
            check("wfull",  32'(wfull),  32'(model_q.size() == DEPTH));
            check("rdata",  32'(rdata),  (model_q.size() == 0) ? 32'h0 : 32'(model_q[0]));
        end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        wrst  = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = '0;

        // Reset held for 5 cycles. Read pulses afterwards must change nothing.
        tick();
        check_en = 1'b1;
        repeat (4) tick();
        wrst = 1'b1;
        tick();
        check("rst_rempty", 32'(rempty), 32'h1);
        check("rst_wfull",  32'(wfull),  32'h0);
        check("rst_rdata",  32'(rdata),  32'h0);
        rinc = 1'b1; tick(); rinc = 1'b0; tick();
        rinc = 1'b1; tick(); rinc = 1'b0;
        check("underflow_rempty", 32'(rempty), 32'h1);
        check("underflow_rdata",  32'(rdata),  32'h0);

        // Single word through the FIFO.
        winc = 1'b1; wdata = 8'hA5; tick(); winc = 1'b0;
        check("one_rempty", 32'(rempty), 32'h0);
        check("one_rdata",  32'(rdata),  32'hA5);
        rinc = 1'b1; tick(); rinc = 1'b0;
        check("one_pop_rempty", 32'(rempty), 32'h1);
        check("one_pop_rdata",  32'(rdata),  32'h0);

        // Fill to full, drop one overflow write, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            winc = 1'b1; wdata = 8'(i); tick();
        end
        winc = 1'b0;
        check("fill_wfull", 32'(wfull), 32'h1);
        winc = 1'b1; wdata = 8'hFF; tick(); winc = 1'b0;
        check("overflow_wfull", 32'(wfull), 32'h1);
        check("overflow_head",  32'(rdata), 32'h00);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 32'(rdata), 32'(i));
            rinc = 1'b1; tick();
        end
        rinc = 1'b0;
        check("drain_rempty", 32'(rempty), 32'h1);

        // Read and write together while full: only the read happens.
        for (int i = 0; i < DEPTH; i++) begin
            winc = 1'b1; wdata = 8'(i); tick();
        end
        winc = 1'b1; rinc = 1'b1; wdata = 8'h77; tick();
        winc = 1'b0; rinc = 1'b0;
        check("full_rw_wfull", 32'(wfull), 32'h0);
        check("full_rw_head",  32'(rdata), 32'h01);
        check("full_rw_count", 32'(model_q.size()), 32'(DEPTH - 1));
        for (int i = 1; i < DEPTH; i++) begin
            check("full_rw_order", 32'(rdata), 32'(i));
            rinc = 1'b1; tick();
        end
        rinc = 1'b0;
        check("full_rw_empty", 32'(rempty), 32'h1);

        // Read and write together while empty: only the write happens.
        winc = 1'b1; rinc = 1'b1; wdata = 8'h5A; tick();
        winc = 1'b0; rinc = 1'b0;
        check("empty_rw_rempty", 32'(rempty), 32'h0);
        check("empty_rw_rdata",  32'(rdata),  32'h5A);
        rinc = 1'b1; tick(); rinc = 1'b0;

        // Mixed-rate streaming with random data. Many writes across pointer
        // wrap are checked against the model queue every cycle.
        for (int c = 0; c < 920; c++) begin
            winc  = (c % 4 == 0);
            rinc  = (c % 3 == 0);
            wdata = 8'($urandom);
            tick();
        end
        winc = 1'b0;
        rinc = 1'b1;
        repeat (DEPTH + 2) tick();
        rinc = 1'b0;
        check("stream_rempty", 32'(rempty), 32'h1);

        // A reset with 5 words stored discards them. Outputs stay idle while
        // reset is held, even with requests asserted.
        for (int i = 0; i < 5; i++) begin
            winc = 1'b1; wdata = 8'(8'h10 + i); tick();
        end
        winc = 1'b0;
        check("pre_rst_head", 32'(rdata), 32'h10);
        wrst = 1'b0; tick();
        check("mid_rst_rempty", 32'(rempty), 32'h1);
        check("mid_rst_wfull",  32'(wfull),  32'h0);
        check("mid_rst_rdata",  32'(rdata),  32'h0);
        winc = 1'b1; rinc = 1'b1; wdata = 8'hEE; tick();
        check("hold_rst_rempty", 32'(rempty), 32'h1);
        check("hold_rst_rdata",  32'(rdata),  32'h0);
        winc = 1'b0; rinc = 1'b0; wrst = 1'b1; tick();
        winc = 1'b1; wdata = 8'h3C; tick(); winc = 1'b0;
        check("post_rst_rdata",  32'(rdata),  32'h3C);
        check("post_rst_rempty", 32'(rempty), 32'h0);
        rinc = 1'b1; tick(); rinc = 1'b0;
        check("post_rst_drain", 32'(rempty), 32'h1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
